// File: rtl/step_drv_pkg.sv
// Shared definitions for the stepper driver: register map, CTRL/STATUS bit
// positions, the phase-to-coil table and the phase-advance rule.
package step_drv_pkg;

  localparam logic [2:0] REG_PWM_INC     = 3'd0;
  localparam logic [2:0] REG_WIDTH_A     = 3'd1;
  localparam logic [2:0] REG_WIDTH_B     = 3'd2;
  localparam logic [2:0] REG_CTRL        = 3'd3;
  localparam logic [2:0] REG_STEP_PERIOD = 3'd4;
  localparam logic [2:0] REG_STEP_COUNT  = 3'd5;
  localparam logic [2:0] REG_STATUS      = 3'd6;
  localparam logic [2:0] REG_POSITION    = 3'd7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_HALF   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } step_state_e;

  // Which half of each coil is energised for a phase index.
  typedef struct packed {
    logic a_pos;
    logic a_neg;
    logic b_pos;
    logic b_neg;
  } coil_t;

  function automatic coil_t coil_of(input logic [2:0] p);
    coil_t c;
    case (p)
      3'd0:    c = 4'b1001;  // A+ B-
      3'd1:    c = 4'b1000;  // A+ B0
      3'd2:    c = 4'b1010;  // A+ B+
      3'd3:    c = 4'b0010;  // A0 B+
      3'd4:    c = 4'b0110;  // A- B+
      3'd5:    c = 4'b0100;  // A- B0
      3'd6:    c = 4'b0101;  // A- B-
      default: c = 4'b0001;  // A0 B-
    endcase
    return c;
  endfunction

  // Full steps always land on an even phase; backward from an odd phase
  // only drops to the even phase just below.
  function automatic logic [2:0] phase_next(input logic [2:0] p, input logic fwd,
                                            input logic half);
    logic [2:0] n;
    if (half)     n = fwd ? p + 3'd1 : p - 3'd1;
    else if (fwd) n = {p[2:1] + 2'd1, 1'b0};
    else if (!p[0]) n = {p[2:1] - 2'd1, 1'b0};
    else          n = {p[2:1], 1'b0};
    return n;
  endfunction

  // Byte-lane merge of a bus write into an existing 32-bit value.
  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/step_motor_channel.sv
// One motor: register file, PWM chopper, step generator FSM, coil pins.
// Bus handshake: wr_i is a one-cycle strobe; the write lands on that edge.
module step_motor_channel
  import step_drv_pkg::*;
#(
  parameter int PWM_W  = 32,
  parameter int STEP_W = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [2:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  output logic        ax_o,
  output logic        ay_o,
  output logic        bx_o,
  output logic        by_o,
  output logic        aen_o,
  output logic        ben_o
);

  logic [PWM_W-1:0]  pwm_inc_q, width_a_q, width_b_q, acc_q;
  logic              pwm_a_q, pwm_b_q;
  logic [3:0]        ctrl_q;
  logic [STEP_W-1:0] period_q, count_q, count_d, timer_q, timer_d;
  logic [31:0]       pos_q, pos_d;
  logic [2:0]        phase_q, phase_d;
  logic              done_q, done_d;
  step_state_e       state_q, state_d;
  logic              ax_q, ay_q, bx_q, by_q, aen_q, ben_q;

  logic              en, fwd, count_wr, start_ok, load, step_fire, done_set;
  logic [STEP_W-1:0] new_count, per_eff;
  coil_t             coil;

  assign en        = ctrl_q[CTRL_EN];
  assign fwd       = ctrl_q[CTRL_DIR];
  assign count_wr  = wr_i && (addr_i == REG_STEP_COUNT);
  assign new_count = STEP_W'(be_merge(32'(count_q), wdata_i, be_i));
  assign start_ok  = count_wr && en && (new_count != '0);
  assign per_eff   = (period_q == '0) ? STEP_W'(1) : period_q;
  assign coil      = coil_of(phase_q);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: disable beats everything, a count write beats a step
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (!en)                                   state_d = ST_IDLE;
        else if (count_wr)                         state_d = (new_count != '0) ? ST_RUN : ST_IDLE;
        else if (timer_q == STEP_W'(1) && count_q == STEP_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: timer load, step strobe, completion strobe
  always_comb begin
    load      = 1'b0;
    step_fire = 1'b0;
    done_set  = 1'b0;
    case (state_q)
      ST_IDLE: load = start_ok;
      ST_RUN: if (en) begin
        if (count_wr) load = (new_count != '0);
        else if (timer_q == STEP_W'(1)) begin
          step_fire = 1'b1;
          done_set  = (count_q == STEP_W'(1));
        end
      end
      default: ;
    endcase
  end

  // Step datapath next-state: count, timer, position, phase, done
  always_comb begin
    count_d = count_q;
    timer_d = timer_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    if (count_wr)       count_d = new_count;
    else if (step_fire) count_d = count_q - STEP_W'(1);
    if (load || step_fire)       timer_d = per_eff;
    else if (state_q == ST_RUN)  timer_d = timer_q - STEP_W'(1);
    if (step_fire) begin
      pos_d   = fwd ? pos_q + 32'd1 : pos_q - 32'd1;
      phase_d = phase_next(phase_q, fwd, ctrl_q[CTRL_HALF]);
    end else if (wr_i && addr_i == REG_POSITION && state_q == ST_IDLE) begin
      pos_d = be_merge(pos_q, wdata_i, be_i);
    end
    done_d = done_set |
             (done_q & ~(wr_i && addr_i == REG_STATUS && be_i[0] && wdata_i[STAT_DONE]));
  end

  // Registers: bus-written configuration plus step datapath state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_inc_q <= '0;
      width_a_q <= '0;
      width_b_q <= '0;
      ctrl_q    <= '0;
      period_q  <= '0;
      count_q   <= '0;
      timer_q   <= '0;
      pos_q     <= '0;
      phase_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      if (wr_i && addr_i == REG_PWM_INC)
        pwm_inc_q <= PWM_W'(be_merge(32'(pwm_inc_q), wdata_i, be_i));
      if (wr_i && addr_i == REG_WIDTH_A)
        width_a_q <= PWM_W'(be_merge(32'(width_a_q), wdata_i, be_i));
      if (wr_i && addr_i == REG_WIDTH_B)
        width_b_q <= PWM_W'(be_merge(32'(width_b_q), wdata_i, be_i));
      if (wr_i && addr_i == REG_CTRL && be_i[0])
        ctrl_q <= wdata_i[3:0];
      if (wr_i && addr_i == REG_STEP_PERIOD)
        period_q <= STEP_W'(be_merge(32'(period_q), wdata_i, be_i));
      count_q <= count_d;
      timer_q <= timer_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  // PWM chopper: free-running accumulator compared against each width
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      pwm_a_q <= 1'b0;
      pwm_b_q <= 1'b0;
    end else begin
      acc_q   <= acc_q + pwm_inc_q;
      pwm_a_q <= (acc_q <= width_a_q);
      pwm_b_q <= (acc_q <= width_b_q);
    end
  end

  // Active-low H-bridge pins, registered from phase, enable and PWM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ax_q  <= 1'b1;
      ay_q  <= 1'b1;
      bx_q  <= 1'b1;
      by_q  <= 1'b1;
      aen_q <= 1'b1;
      ben_q <= 1'b1;
    end else begin
      ax_q  <= ~(en & coil.a_pos & pwm_a_q);
      ay_q  <= ~(en & coil.a_neg & pwm_a_q);
      bx_q  <= ~(en & coil.b_pos & pwm_b_q);
      by_q  <= ~(en & coil.b_neg & pwm_b_q);
      aen_q <= ~en;
      ben_q <= ~en;
    end
  end

  // Read value for the addressed register (registered at the top)
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      REG_PWM_INC:     rdata_o = 32'(pwm_inc_q);
      REG_WIDTH_A:     rdata_o = 32'(width_a_q);
      REG_WIDTH_B:     rdata_o = 32'(width_b_q);
      REG_CTRL:        rdata_o = {28'd0, ctrl_q};
      REG_STEP_PERIOD: rdata_o = 32'(period_q);
      REG_STEP_COUNT:  rdata_o = 32'(count_q);
      REG_STATUS:      rdata_o = {30'd0, done_q, state_q == ST_RUN};
      default:         rdata_o = pos_q;
    endcase
  end

  assign irq_o = done_q & ctrl_q[CTRL_IRQ_EN];
  assign ax_o  = ax_q;
  assign ay_o  = ay_q;
  assign bx_o  = bx_q;
  assign by_o  = by_q;
  assign aen_o = aen_q;
  assign ben_o = ben_q;

endmodule

// File: rtl/multi_axis_step_motor_driver.sv
// Avalon-MM front end for NUM_MOTORS stepper channels: address decode,
// registered read mux (latency 1, never stalls) and interrupt OR.
module multi_axis_step_motor_driver
  import step_drv_pkg::*;
#(
  parameter int NUM_MOTORS = 2,
  parameter int PWM_W      = 32,
  parameter int STEP_W     = 24,
  localparam int AW        = 3 + $clog2(NUM_MOTORS)
) (
  input  logic                  csi_MCLK_clk,
  input  logic                  rsi_MRST_reset,
  input  logic [AW-1:0]         avs_ctrl_address,
  input  logic                  avs_ctrl_write,
  input  logic                  avs_ctrl_read,
  input  logic [31:0]           avs_ctrl_writedata,
  input  logic [3:0]            avs_ctrl_byteenable,
  output logic [31:0]           avs_ctrl_readdata,
  output logic                  avs_ctrl_waitrequest,
  output logic                  ins_irq,
  output logic [NUM_MOTORS-1:0] AX,
  output logic [NUM_MOTORS-1:0] AY,
  output logic [NUM_MOTORS-1:0] BX,
  output logic [NUM_MOTORS-1:0] BY,
  output logic [NUM_MOTORS-1:0] AE,
  output logic [NUM_MOTORS-1:0] BE
);

  logic [31:0]           ch_idx;
  logic [31:0]           ch_rdata [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] ch_irq;
  logic [31:0]           rd_mux, readdata_q;

  assign ch_idx = 32'(avs_ctrl_address) >> 3;

  for (genvar c = 0; c < NUM_MOTORS; c++) begin : g_ch
    step_motor_channel #(.PWM_W(PWM_W), .STEP_W(STEP_W)) u_ch (
      .clk_i   (csi_MCLK_clk),
      .rst_i   (rsi_MRST_reset),
      .wr_i    (avs_ctrl_write && (ch_idx == 32'(c))),
      .addr_i  (avs_ctrl_address[2:0]),
      .wdata_i (avs_ctrl_writedata),
      .be_i    (avs_ctrl_byteenable),
      .rdata_o (ch_rdata[c]),
      .irq_o   (ch_irq[c]),
      .ax_o    (AX[c]),
      .ay_o    (AY[c]),
      .bx_o    (BX[c]),
      .by_o    (BY[c]),
      .aen_o   (AE[c]),
      .ben_o   (BE[c])
    );
  end

  // Select the addressed channel's register; unmapped channels read 0
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_MOTORS; c++)
      if (ch_idx == 32'(c)) rd_mux = ch_rdata[c];
  end

  // Read data captured on the read strobe and held until the next read
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset)     readdata_q <= '0;
    else if (avs_ctrl_read) readdata_q <= rd_mux;
  end

  assign avs_ctrl_readdata    = readdata_q;
  assign avs_ctrl_waitrequest = 1'b0;
  assign ins_irq              = |ch_irq;

endmodule

// File: tb/tb_multi_axis_step_motor_driver.sv
// Directed and randomized checks of the stepper driver against a
// position/phase model kept as plain integers.
module tb_multi_axis_step_motor_driver;

  localparam int NM = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          write, read;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic [31:0]   readdata;
  logic          waitreq, irq;
  logic [NM-1:0] AX, AY, BX, BY, AE, BE;

  int n_checks = 0;
  int n_fail   = 0;
  int phase_m[NM];
  int pos_m[NM];

  multi_axis_step_motor_driver #(.NUM_MOTORS(NM)) dut (
    .csi_MCLK_clk         (clk),
    .rsi_MRST_reset       (rst),
    .avs_ctrl_address     (addr),
    .avs_ctrl_write       (write),
    .avs_ctrl_read        (read),
    .avs_ctrl_writedata   (wdata),
    .avs_ctrl_byteenable  (be),
    .avs_ctrl_readdata    (readdata),
    .avs_ctrl_waitrequest (waitreq),
    .ins_irq              (irq),
    .AX (AX), .AY (AY), .BX (BX), .BY (BY), .AE (AE), .BE (BE)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input int ch, input int r, input logic [31:0] d,
                           input logic [3:0] lanes = 4'hF);
    @(negedge clk);
    addr  = AW'(ch * 8 + r);
    wdata = d;
    be    = lanes;
    write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
    be = 4'hF;
  endtask

  task automatic bus_read(input int ch, input int r, output logic [31:0] d);
    @(negedge clk);
    addr = AW'(ch * 8 + r);
    read = 1'b1;
    @(posedge clk);
    #1 read = 1'b0;
    d = readdata;
  endtask

  // Phase rule: half steps move one position; full steps land on the next
  // even phase in the direction of travel.
  function automatic int adv(input int p, input bit fwd, input bit half);
    if (half) return fwd ? (p + 1) % 8 : (p + 7) % 8;
    if (fwd)  return ((p / 2 + 1) * 2) % 8;
    return (p % 2 == 1) ? p - 1 : (p + 6) % 8;
  endfunction

  task automatic model_move(input int ch, input bit fwd, input bit half, input int n);
    for (int i = 0; i < n; i++) begin
      phase_m[ch] = adv(phase_m[ch], fwd, half);
      pos_m[ch]   = pos_m[ch] + (fwd ? 1 : -1);
    end
  endtask

  // Expects PWM duty pinned at 100% so pins reflect only the phase.
  task automatic check_pins(input string tag, input int ch, input int p);
    logic [3:0] exp4, obs4;
    @(negedge clk);
    exp4 = ~{p <= 2, p >= 4 && p <= 6, p >= 2 && p <= 4, p >= 6 || p == 0};
    obs4 = {AX[ch], AY[ch], BX[ch], BY[ch]};
    check({tag, "_coils"}, 32'(obs4), 32'(exp4));
    check({tag, "_en"}, 32'({AE[ch], BE[ch]}), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  s;
    logic        ay_all, ae_any;
    int          ch, per, eff, n;
    bit          fwd, half;

    rst = 1'b1; write = 1'b0; read = 1'b0; addr = '0; wdata = '0; be = 4'hF;
    for (int i = 0; i < NM; i++) begin phase_m[i] = 0; pos_m[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_AX", 32'(AX), 32'h3);
    check("rst_AY", 32'(AY), 32'h3);
    check("rst_BX", 32'(BX), 32'h3);
    check("rst_BY", 32'(BY), 32'h3);
    check("rst_AE", 32'(AE), 32'h3);
    check("rst_BE", 32'(BE), 32'h3);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("waitrequest", 32'(waitreq), 32'd0);
    for (int c = 0; c < NM; c++)
      for (int r = 0; r < 8; r++) begin
        bus_read(c, r, rd);
        check($sformatf("rst_reg_c%0d_r%0d", c, r), rd, 32'd0);
      end

    // Ch0 PWM duty: 3 of every 4 cycles on, phase 0 drives A+ (AX)
    bus_write(0, 0, 32'h4000_0000);
    bus_write(0, 1, 32'h8000_0000);
    bus_write(0, 3, 32'h1);
    repeat (4) @(posedge clk);
    s = '0; ay_all = 1'b1; ae_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s[i]   = AX[0];
      ay_all = ay_all & AY[0];
      ae_any = ae_any | AE[0];
    end
    check("ch0_duty_pattern", 32'(s == 8'h11 || s == 8'h22 || s == 8'h44 || s == 8'h88), 32'd1);
    check("ch0_AY_idle", 32'(ay_all), 32'd1);
    check("ch0_AE_active", 32'(ae_any), 32'd0);

    // Ch1 half-step forward, period 5, 10 steps
    bus_write(1, 3, 32'h7);
    bus_write(1, 4, 32'd5);
    bus_write(1, 5, 32'd10);
    repeat (49) @(posedge clk);
    bus_read(1, 6, rd);  check("ch1_busy_last_cycle", rd, 32'h1);
    bus_read(1, 6, rd);  check("ch1_done", rd, 32'h2);
    model_move(1, 1, 1, 10);
    bus_read(1, 7, rd);  check("ch1_position", rd, 32'd10);
    bus_read(1, 5, rd);  check("ch1_remaining", rd, 32'd0);
    check_pins("ch1_phase2", 1, 2);

    // Ch0: half-step to phase 3, zero position, then full-step backward
    bus_write(0, 1, 32'hFFFF_FFFF);
    bus_write(0, 2, 32'hFFFF_FFFF);
    bus_write(0, 3, 32'h7);
    bus_write(0, 4, 32'd1);
    bus_write(0, 5, 32'd3);
    repeat (3) @(posedge clk);
    model_move(0, 1, 1, 3);
    bus_write(0, 7, 32'd0);
    pos_m[0] = 0;
    bus_write(0, 6, 32'h2);
    bus_write(0, 3, 32'h9);
    bus_write(0, 4, 32'd2);
    bus_write(0, 5, 32'd2);
    repeat (3) @(posedge clk);
    check_pins("ch0_back_p2", 0, 2);
    repeat (2) @(posedge clk);
    check_pins("ch0_back_p0", 0, 0);
    check("ch0_irq_set", 32'(irq), 32'd1);
    model_move(0, 0, 0, 2);
    bus_read(0, 7, rd);  check("ch0_position_neg2", rd, 32'hFFFF_FFFE);
    bus_read(0, 6, rd);  check("ch0_done", rd, 32'h2);
    check("ch0_irq_held", 32'(irq), 32'd1);
    bus_write(0, 6, 32'h2);
    @(negedge clk);
    check("ch0_irq_cleared", 32'(irq), 32'd0);

    // Ch1 abort after 3 steps; POSITION write during the move is ignored
    bus_write(1, 6, 32'h2);
    bus_write(1, 7, 32'd0);
    pos_m[1] = 0;
    bus_write(1, 4, 32'd4);
    bus_write(1, 5, 32'd100);
    repeat (5) @(posedge clk);
    bus_write(1, 7, 32'h55);
    repeat (7) @(posedge clk);
    bus_write(1, 5, 32'd0);
    model_move(1, 1, 1, 3);
    bus_read(1, 6, rd);  check("ch1_abort_status", rd, 32'h0);
    bus_read(1, 7, rd);  check("ch1_abort_position", rd, 32'd3);
    bus_write(1, 7, 32'h1234);
    pos_m[1] = 32'h1234;
    bus_read(1, 7, rd);  check("ch1_position_write", rd, 32'h1234);

    // Ch1: count rewrite on the step cycle suppresses that step
    bus_write(1, 4, 32'd3);
    bus_write(1, 5, 32'd5);
    repeat (2) @(posedge clk);
    bus_write(1, 5, 32'd2);
    repeat (5) @(posedge clk);
    bus_read(1, 6, rd);  check("ch1_rewrite_busy", rd, 32'h1);
    bus_read(1, 6, rd);  check("ch1_rewrite_done", rd, 32'h2);
    model_move(1, 1, 1, 2);
    bus_read(1, 7, rd);  check("ch1_rewrite_position", rd, 32'(pos_m[1]));
    check_pins("ch1_rewrite", 1, phase_m[1]);

    // Ch0: period 0 steps every cycle; W1C on the completing edge loses
    bus_write(0, 3, 32'hF);
    bus_write(0, 4, 32'd0);
    bus_write(0, 5, 32'd4);
    repeat (3) @(posedge clk);
    bus_write(0, 6, 32'h2);
    model_move(0, 1, 1, 4);
    bus_read(0, 6, rd);  check("ch0_done_beats_w1c", rd, 32'h2);
    bus_read(0, 7, rd);  check("ch0_period0_position", rd, 32'd2);
    check("ch0_period0_irq", 32'(irq), 32'd1);
    check_pins("ch0_period0", 0, phase_m[0]);
    bus_write(0, 6, 32'h2);
    bus_write(1, 6, 32'h2);

    // Byte-lane write on STEP_PERIOD
    bus_write(1, 4, 32'hAABB_CCDD, 4'b0101);
    bus_read(1, 4, rd);  check("ch1_period_bytelanes", rd, 32'h00BB_00DD);

    // Randomized moves
    for (int it = 0; it < 8; it++) begin
      ch   = $urandom_range(0, NM - 1);
      fwd  = 1'($urandom_range(0, 1));
      half = 1'($urandom_range(0, 1));
      per  = $urandom_range(0, 6);
      n    = $urandom_range(1, 12);
      eff  = (per == 0) ? 1 : per;
      bus_write(ch, 3, {29'd0, half, fwd, 1'b1});
      bus_write(ch, 4, 32'(per));
      bus_write(ch, 5, 32'(n));
      repeat (n * eff - 1) @(posedge clk);
      bus_read(ch, 6, rd);  check($sformatf("rnd%0d_busy", it), rd, 32'h1);
      bus_read(ch, 6, rd);  check($sformatf("rnd%0d_done", it), rd, 32'h2);
      model_move(ch, fwd, half, n);
      bus_read(ch, 7, rd);  check($sformatf("rnd%0d_position", it), rd, 32'(pos_m[ch]));
      check_pins($sformatf("rnd%0d", it), ch, phase_m[ch]);
      bus_write(ch, 6, 32'h2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
